// File: rtl/pa_dtu_halt_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pa_dtu_halt_ctrl_pkg
// Shared DTU definitions: halt-controller state encoding, dcsr.cause codes
// and the cause-priority helper used when a halt request is accepted.
// -----------------------------------------------------------------------------
package pa_dtu_halt_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RUN        = 3'd0,
    ST_STEP       = 3'd1,
    ST_HALT_REQ   = 3'd2,
    ST_HALTED     = 3'd3,
    ST_RESUME_REQ = 3'd4
  } dtu_state_e;

  localparam int unsigned DTU_CAUSE_PKG_W = 3;

  localparam logic [DTU_CAUSE_PKG_W-1:0] CAUSE_EBREAK  = 3'd1;
  localparam logic [DTU_CAUSE_PKG_W-1:0] CAUSE_TRIGGER = 3'd2;
  localparam logic [DTU_CAUSE_PKG_W-1:0] CAUSE_HALTREQ = 3'd3;
  localparam logic [DTU_CAUSE_PKG_W-1:0] CAUSE_STEP    = 3'd4;

  // Priority: trigger > ebreak > haltreq > step. Step is the fallback, so the
  // caller only invokes this once it knows some halt source is active.
  function automatic logic [DTU_CAUSE_PKG_W-1:0] dtu_cause_sel(
    input logic trigger,
    input logic ebreak,
    input logic haltreq
  );
    if (trigger) begin
      return CAUSE_TRIGGER;
    end else if (ebreak) begin
      return CAUSE_EBREAK;
    end else if (haltreq) begin
      return CAUSE_HALTREQ;
    end
    return CAUSE_STEP;
  endfunction

endpackage

// File: rtl/pa_dtu_halt_ctrl.sv
// -----------------------------------------------------------------------------
// pa_dtu_halt_ctrl
// Debug halt/resume sequencer between the debug module and the retire unit.
// Collects halt sources, handshakes with the RTU to enter and leave debug
// mode, latches the debug-entry cause and supports single-step re-entry.
//
// Ports
//   forever_cpuclk        in   free-running core clock
//   cpurst                in   async active-high reset
//   dm_dtu_haltreq        in   level halt request from debug module
//   dm_dtu_resumereq      in   level resume request from debug module
//   pending_halt          in   trigger hit with action = debug mode
//   rtu_dtu_retire_ebreak in   retiring ebreak with dcsr.ebreakm set
//   rtu_dtu_retire_vld    in   instruction retired this cycle
//   dcsr_step             in   single-step enable
//   rtu_dtu_halt_ack      in   core entered debug mode
//   rtu_dtu_resume_ack    in   core left debug mode
//   dtu_rtu_halt_req      out  halt request to RTU
//   dtu_rtu_resume_req    out  resume request to RTU
//   dtu_dm_halted         out  hart halted status
//   dtu_dm_resumeack      out  one-cycle resume-done pulse
//   dtu_dcsr_cause        out  latched debug-entry cause
//   dtu_dcsr_cause_vld    out  one-cycle pulse: write cause into dcsr
//
// state         | meaning
// --------------+-----------------------------------------------------------
// ST_RUN        | normal execution, watching trigger/ebreak/haltreq
// ST_STEP       | resumed with dcsr.step, halts on the first retirement
// ST_HALT_REQ   | halt_req to RTU held until halt_ack
// ST_HALTED     | in debug mode, waiting for resumereq
// ST_RESUME_REQ | resume_req to RTU held until resume_ack
// -----------------------------------------------------------------------------
module pa_dtu_halt_ctrl
  import pa_dtu_halt_ctrl_pkg::*;
#(
  parameter int CAUSE_W = 3
) (
  input  logic               forever_cpuclk,
  input  logic               cpurst,
  input  logic               dm_dtu_haltreq,
  input  logic               dm_dtu_resumereq,
  input  logic               pending_halt,
  input  logic               rtu_dtu_retire_ebreak,
  input  logic               rtu_dtu_retire_vld,
  input  logic               dcsr_step,
  input  logic               rtu_dtu_halt_ack,
  input  logic               rtu_dtu_resume_ack,
  output logic               dtu_rtu_halt_req,
  output logic               dtu_rtu_resume_req,
  output logic               dtu_dm_halted,
  output logic               dtu_dm_resumeack,
  output logic [CAUSE_W-1:0] dtu_dcsr_cause,
  output logic               dtu_dcsr_cause_vld
);

  dtu_state_e         state_q, state_d;
  logic [CAUSE_W-1:0] cause_q, cause_d;
  logic               halt_req_q, halt_req_d;
  logic               resume_req_q, resume_req_d;
  logic               halted_q, halted_d;
  logic               resumeack_q, resumeack_d;
  logic               cause_vld_q, cause_vld_d;
  logic               halt_src;

  assign halt_src = pending_halt | rtu_dtu_retire_ebreak | dm_dtu_haltreq;

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      state_q      <= ST_RUN;
      cause_q      <= '0;
      halt_req_q   <= 1'b0;
      resume_req_q <= 1'b0;
      halted_q     <= 1'b0;
      resumeack_q  <= 1'b0;
      cause_vld_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cause_q      <= cause_d;
      halt_req_q   <= halt_req_d;
      resume_req_q <= resume_req_d;
      halted_q     <= halted_d;
      resumeack_q  <= resumeack_d;
      cause_vld_q  <= cause_vld_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;

    unique case (state_q)
      ST_RUN: begin
        if (halt_src) begin
          state_d = ST_HALT_REQ;
          cause_d = CAUSE_W'(dtu_cause_sel(pending_halt, rtu_dtu_retire_ebreak,
                                           dm_dtu_haltreq));
        end
      end
      ST_STEP: begin
        // With no explicit source active the selector falls back to step.
        if (halt_src || rtu_dtu_retire_vld) begin
          state_d = ST_HALT_REQ;
          cause_d = CAUSE_W'(dtu_cause_sel(pending_halt, rtu_dtu_retire_ebreak,
                                           dm_dtu_haltreq));
        end
      end
      ST_HALT_REQ: begin
        if (rtu_dtu_halt_ack) begin
          state_d = ST_HALTED;
        end
      end
      ST_HALTED: begin
        if (dm_dtu_resumereq) begin
          state_d = ST_RESUME_REQ;
        end
      end
      ST_RESUME_REQ: begin
        if (rtu_dtu_resume_ack) begin
          state_d = dcsr_step ? ST_STEP : ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    // Outputs are decoded from the next state so every port comes from a flop
    // yet still tracks the state it belongs to without an extra cycle of lag.
    halt_req_d   = (state_d == ST_HALT_REQ);
    resume_req_d = (state_d == ST_RESUME_REQ);
    halted_d     = (state_d == ST_HALTED) || (state_d == ST_RESUME_REQ);
    resumeack_d  = (state_q == ST_RESUME_REQ) && (state_d != ST_RESUME_REQ);
    cause_vld_d  = (state_q == ST_HALT_REQ) && (state_d == ST_HALTED);
  end

  assign dtu_rtu_halt_req   = halt_req_q;
  assign dtu_rtu_resume_req = resume_req_q;
  assign dtu_dm_halted      = halted_q;
  assign dtu_dm_resumeack   = resumeack_q;
  assign dtu_dcsr_cause     = cause_q;
  assign dtu_dcsr_cause_vld = cause_vld_q;

endmodule

// File: tb/tb_pa_dtu_halt_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pa_dtu_halt_ctrl
// Directed bench for the debug halt sequencer. A behavioural model of the
// debug-mode rules predicts every output each cycle; directed scenarios add
// hand-computed literal expectations on top.
// -----------------------------------------------------------------------------
module tb_pa_dtu_halt_ctrl;

  localparam int CAUSE_W = 3;

  logic clk = 1'b0;
  logic rst;
  logic haltreq, resumereq, trig, ebrk, retire, step, hack, rack;
  logic halt_req, resume_req, halted, resumeack, cause_vld;
  logic [CAUSE_W-1:0] cause;

  int n_chk  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  pa_dtu_halt_ctrl #(.CAUSE_W(CAUSE_W)) dut (
    .forever_cpuclk        (clk),
    .cpurst                (rst),
    .dm_dtu_haltreq        (haltreq),
    .dm_dtu_resumereq      (resumereq),
    .pending_halt          (trig),
    .rtu_dtu_retire_ebreak (ebrk),
    .rtu_dtu_retire_vld    (retire),
    .dcsr_step             (step),
    .rtu_dtu_halt_ack      (hack),
    .rtu_dtu_resume_ack    (rack),
    .dtu_rtu_halt_req      (halt_req),
    .dtu_rtu_resume_req    (resume_req),
    .dtu_dm_halted         (halted),
    .dtu_dm_resumeack      (resumeack),
    .dtu_dcsr_cause        (cause),
    .dtu_dcsr_cause_vld    (cause_vld)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model of debug-mode behaviour expressed as a few flags:
  // halting = request outstanding to the core, halted = in debug mode,
  // resuming = resume outstanding, stepping = resumed with single-step.
  bit m_halting, m_halted, m_resuming, m_stepping, m_vld, m_rack;
  int m_cause;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_halting = 0; m_halted = 0; m_resuming = 0; m_stepping = 0;
      m_vld = 0; m_rack = 0; m_cause = 0;
    end else begin
      m_vld = 0;
      m_rack = 0;
      if (m_halting) begin
        if (hack) begin
          m_halting = 0; m_halted = 1; m_vld = 1;
        end
      end else if (m_resuming) begin
        if (rack) begin
          m_resuming = 0; m_halted = 0; m_rack = 1; m_stepping = step;
        end
      end else if (m_halted) begin
        if (resumereq) m_resuming = 1;
      end else if (trig || ebrk || haltreq || (m_stepping && retire)) begin
        m_halting = 1;
        m_stepping = 0;
        if (trig)         m_cause = 2;
        else if (ebrk)    m_cause = 1;
        else if (haltreq) m_cause = 3;
        else              m_cause = 4;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("mdl_halt_req",   halt_req,   m_halting);
      chk("mdl_resume_req", resume_req, m_resuming);
      chk("mdl_halted",     halted,     m_halted);
      chk("mdl_resumeack",  resumeack,  m_rack);
      chk("mdl_cause",      cause,      m_cause);
      chk("mdl_cause_vld",  cause_vld,  m_vld);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic ack_halt(input int exp_cause, input string nm);
    hack = 1; tick(); hack = 0;
    chk({nm, "_halted"}, halted, 1);
    chk({nm, "_cause"}, cause, exp_cause);
    chk({nm, "_cause_vld"}, cause_vld, 1);
    chk({nm, "_halt_req_drop"}, halt_req, 0);
    tick();
    chk({nm, "_cause_vld_once"}, cause_vld, 0);
  endtask

  // Resume request, ack two cycles later with dcsr_step presented that cycle.
  task automatic do_resume(input logic step_v, input string nm);
    resumereq = 1; tick(); resumereq = 0;
    chk({nm, "_resume_req"}, resume_req, 1);
    tick();
    rack = 1; step = step_v; tick(); rack = 0; step = 0;
    chk({nm, "_resumeack"}, resumeack, 1);
    chk({nm, "_halted_clr"}, halted, 0);
    chk({nm, "_resume_req_drop"}, resume_req, 0);
    tick();
    chk({nm, "_resumeack_once"}, resumeack, 0);
  endtask

  initial begin
    haltreq = 0; resumereq = 0; trig = 0; ebrk = 0; retire = 0;
    step = 0; hack = 0; rack = 0;
    rst = 1;
    repeat (3) tick();
    chk("rst_halt_req", halt_req, 0);
    chk("rst_resume_req", resume_req, 0);
    chk("rst_halted", halted, 0);
    chk("rst_resumeack", resumeack, 0);
    chk("rst_cause", cause, 0);
    chk("rst_cause_vld", cause_vld, 0);
    rst = 0;
    cmp_en = 1;
    tick();

    // haltreq in RUN, ack three cycles later
    haltreq = 1;
    repeat (3) begin
      tick(); haltreq = 0;
      chk("s1_halt_req_held", halt_req, 1);
    end
    ack_halt(3, "s1");

    // halt sources are ignored while halted
    haltreq = 1; trig = 1; tick(); tick(); haltreq = 0; trig = 0;
    chk("s1_ignore_halt_req", halt_req, 0);
    chk("s1_ignore_halted", halted, 1);

    // resume with single-step, one retirement re-halts with cause 4
    do_resume(1, "s2");
    chk("s2_step_idle", halt_req, 0);
    retire = 1; tick(); retire = 0;
    chk("s2_step_halt_req", halt_req, 1);
    ack_halt(4, "s2");

    // step with ebreak on the same retirement
    do_resume(1, "s3");
    retire = 1; ebrk = 1; tick(); retire = 0; ebrk = 0;
    chk("s3_halt_req", halt_req, 1);
    ack_halt(1, "s3");

    // resume to RUN; resumereq there is a no-op; trigger beats haltreq
    do_resume(0, "s4");
    resumereq = 1; tick(); resumereq = 0;
    chk("s4_resume_noop", resume_req, 0);
    retire = 1; tick(); retire = 0;
    chk("s4_run_retire_noop", halt_req, 0);
    trig = 1; haltreq = 1; tick(); trig = 0; haltreq = 0;
    chk("s4_halt_req", halt_req, 1);
    ack_halt(2, "s4");

    // haltreq held across the resume re-halts right after it completes
    haltreq = 1;
    do_resume(0, "s5");
    chk("s5_rehalt", halt_req, 1);
    haltreq = 0;
    ack_halt(3, "s5");

    // acks arriving with the request-state entry are taken a cycle later
    do_resume(0, "s6r");
    haltreq = 1; hack = 1; tick(); haltreq = 0;
    chk("s6_ack_early_halt_req", halt_req, 1);
    chk("s6_ack_early_halted", halted, 0);
    tick(); hack = 0;
    chk("s6_ack_late_halted", halted, 1);
    chk("s6_ack_late_cause", cause, 3);
    tick();
    resumereq = 1; rack = 1; tick(); resumereq = 0;
    chk("s6_rack_early_req", resume_req, 1);
    chk("s6_rack_early_ack", resumeack, 0);
    tick(); rack = 0;
    chk("s6_rack_late_ack", resumeack, 1);
    tick();

    // reset during HALT_REQ with an ack in flight
    trig = 1; tick(); trig = 0;
    chk("s7_halt_req", halt_req, 1);
    chk("s7_cause_pre", cause, 2);
    hack = 1; rst = 1; tick();
    chk("s7_rst_halt_req", halt_req, 0);
    chk("s7_rst_cause", cause, 0);
    chk("s7_rst_cause_vld", cause_vld, 0);
    chk("s7_rst_halted", halted, 0);
    rst = 0; tick();
    chk("s7_post_halted", halted, 0);
    chk("s7_post_cause_vld", cause_vld, 0);
    hack = 0; tick();
    chk("s7_post_halt_req", halt_req, 0);

    cmp_en = 0;
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pa_dtu_halt_ctrl.md
PA_DTU_HALT_CTRL -- requirements
Module: pa_dtu_halt_ctrl

Interface
REQ-001 SHALL provide parameter: CAUSE_W, 3, width of dcsr.cause field.
REQ-002 SHALL have one clock and one reset: reset is asynchronous and active-high.
REQ-003 SHALL provide port: forever_cpuclk  in  1  free-running core clock.
REQ-004 SHALL provide port: cpurst  in  1  asynchronous active-high reset.
REQ-005 SHALL provide port: dm_dtu_haltreq  in  1  level halt request from debug module.
REQ-006 SHALL provide port: dm_dtu_resumereq  in  1  level resume request from debug module.
REQ-007 SHALL provide port: pending_halt  in  1  trigger-module action=debug-mode hit.
REQ-008 SHALL provide port: rtu_dtu_retire_ebreak  in  1  retiring ebreak with dcsr.ebreakm set.
REQ-009 SHALL provide port: rtu_dtu_retire_vld  in  1  instruction retired this cycle.
REQ-010 SHALL provide port: dcsr_step  in  1  single-step enable.
REQ-011 SHALL provide port: rtu_dtu_halt_ack  in  1  core entered debug mode.
REQ-012 SHALL provide port: rtu_dtu_resume_ack  in  1  core left debug mode.
REQ-013 SHALL provide port: dtu_rtu_halt_req  out  1  halt request to RTU.
REQ-014 SHALL provide port: dtu_rtu_resume_req  out  1  resume request to RTU.
REQ-015 SHALL provide port: dtu_dm_halted  out  1  hart halted status.
REQ-016 SHALL provide port: dtu_dm_resumeack  out  1  one-cycle resume-done pulse.
REQ-017 SHALL provide port: dtu_dcsr_cause  out  CAUSE_W  latched debug-entry cause.
REQ-018 SHALL provide port: dtu_dcsr_cause_vld  out  1  one-cycle pulse: write cause into dcsr.

Function
REQ-019 SHALL implement FSM states RUN, STEP, HALT_REQ, HALTED, RESUME_REQ; all outputs registered.
REQ-020 SHALL, in RUN, move to HALT_REQ next edge when pending_halt, rtu_dtu_retire_ebreak or dm_dtu_haltreq is 1.
REQ-021 SHALL latch cause on the HALT_REQ-entry edge by priority: trigger=2 > ebreak=1 > haltreq=3 > step=4.
REQ-022 SHALL assert dtu_rtu_halt_req during HALT_REQ, held until rtu_dtu_halt_ack; halt sources ignored there.
REQ-023 SHALL, on rtu_dtu_halt_ack in HALT_REQ, enter HALTED: dtu_dm_halted=1, dtu_dcsr_cause_vld pulses exactly one cycle.
REQ-024 SHALL, in HALTED, ignore halt sources and go to RESUME_REQ on dm_dtu_resumereq.
REQ-025 SHALL assert dtu_rtu_resume_req during RESUME_REQ, held until rtu_dtu_resume_ack.
REQ-026 SHALL, on rtu_dtu_resume_ack, clear dtu_dm_halted, pulse dtu_dm_resumeack one cycle, and enter STEP if dcsr_step (sampled that cycle) else RUN.
REQ-027 SHALL, in STEP, go to HALT_REQ on first rtu_dtu_retire_vld with cause 4 unless trigger/ebreak/haltreq same cycle (REQ-021 priority).
REQ-028 SHALL treat dm_dtu_resumereq in RUN/STEP/HALT_REQ as no-op; haltreq held during RESUME_REQ re-halts from RUN after resume completes.
REQ-029 SHALL treat an ack arriving in the same cycle as its request-state entry as accepted the following cycle only (no combinational bypass).

Reset
REQ-030 SHALL on cpurst force state RUN and all outputs 0, including dtu_dcsr_cause=0, regardless of in-flight handshake.
REQ-031 SHALL discard any pending ack seen during reset; first transition occurs on first edge after cpurst deasserts.

Structure
REQ-032 SHALL place state encoding and cause constants (1,2,3,4) in the shared DTU package.
REQ-033 SHALL be a single module with no sub-modules; clock gating not required.

Verification
REQ-034 SHALL cover: haltreq=1 in RUN, halt_ack 3 cycles later -> halt_req high 3 cycles, halted=1, cause=3, cause_vld one pulse.
REQ-035 SHALL cover: pending_halt and haltreq same cycle -> cause=2.
REQ-036 SHALL cover: halted, resumereq, resume_ack 2 cycles later, dcsr_step=1, one retire -> resumeack pulse, halt re-entered with cause=4.
REQ-037 SHALL cover: STEP with retire_vld and retire_ebreak same cycle -> cause=1.
REQ-038 SHALL cover: cpurst asserted during HALT_REQ -> halt_req=0 next cycle, state RUN, cause=0, no cause_vld pulse.
